// File: rtl/sipo_frame_receiver.sv
// Serial frame receiver: start bit, N data bits MSB-first, optional even parity, then a stop bit (0).
// The assembled word is presented on a valid/ready port. Define PARITY_EN to enable the parity bit.
module sipo_frame_receiver #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         serial_in,
  input  logic         bit_en,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         frame_err,
  output logic         overrun,
  output logic         parity_err
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

`ifdef PARITY_EN
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

  state_t          state_q;
  logic [N-1:0]    shift_q;
  logic [N-1:0]    shift_d;
  logic [CW-1:0]   count_q;
  logic [N-1:0]    out_data_q;
  logic            out_valid_q;
  logic            frame_err_q;
  logic            overrun_q;
  logic            parity_bad;

  assign shift_d = {shift_q[N-2:0], serial_in};

`ifdef PARITY_EN
  logic parity_q;
  logic parity_err_q;
  // Even parity: data bits plus parity bit must XOR to zero.
  assign parity_bad = ^{shift_q, parity_q};
  assign parity_err = parity_err_q;
`else
  assign parity_bad = 1'b0;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      count_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef PARITY_EN
      parity_q     <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef PARITY_EN
      parity_err_q <= 1'b0;
`endif
      // A completed transfer clears valid; a word loading below in the same cycle overrides this.
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (bit_en) begin
        case (state_q)
          IDLE: begin
            if (serial_in) begin
              state_q <= DATA;
              count_q <= '0;
            end
          end
          DATA: begin
            shift_q <= shift_d;
            count_q <= count_q + 1'b1;
            if (count_q == LAST_BIT) begin
`ifdef PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end
          end
`ifdef PARITY_EN
          PARITY: begin
            parity_q <= serial_in;
            state_q  <= STOP;
          end
`endif
          STOP: begin
            state_q <= IDLE;
            if (serial_in) begin
              frame_err_q <= 1'b1;
            end else if (parity_bad) begin
`ifdef PARITY_EN
              parity_err_q <= 1'b1;
`endif
            end else if (out_valid_q && !out_ready) begin
              overrun_q <= 1'b1;
            end else begin
              out_data_q  <= shift_q;
              out_valid_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != IDLE);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_sipo_frame_receiver.sv
// Directed bench for sipo_frame_receiver (N=8); the parity step runs only when PARITY_EN is defined.
module tb_sipo_frame_receiver;

  logic       clk = 1'b0;
  logic       reset;
  logic       serial_in;
  logic       bit_en;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  int total = 0;
  int bad   = 0;

  sipo_frame_receiver #(.N(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .serial_in (serial_in),
    .bit_en    (bit_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; the task returns one full cycle later, after the rising edge.
  task automatic tick(input logic b, input logic en);
    serial_in = b;
    bit_en    = en;
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_head(input logic [7:0] d);
    tick(1'b1, 1'b1);
    for (int i = 7; i >= 0; i--) tick(d[i], 1'b1);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_head(d);
`ifdef PARITY_EN
    tick(^d, 1'b1);
`endif
    tick(stop, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; serial_in = 1'b0; bit_en = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    check("rst_valid", 16'(out_valid), 16'h0);
    check("rst_data", 16'(out_data), 16'h00);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_errs", {13'h0, frame_err, overrun, parity_err}, 16'h0);
    reset = 1'b0;
    tick(1'b0, 1'b1);
    check("idle_on_zero", 16'(busy), 16'h0);

    // 1: single frame, consumer ready
    out_ready = 1'b1;
    send_head(8'hA5);
`ifdef PARITY_EN
    tick(1'b0, 1'b1);
`endif
    check("t1_busy_before_stop", 16'(busy), 16'h1);
    check("t1_valid_before_stop", 16'(out_valid), 16'h0);
    tick(1'b0, 1'b1);
    check("t1_valid", 16'(out_valid), 16'h1);
    check("t1_data", 16'(out_data), 16'hA5);
    check("t1_idle", 16'(busy), 16'h0);
    tick(1'b0, 1'b1);
    check("t1_valid_one_cycle", 16'(out_valid), 16'h0);
    $display("txn 1: frame A5 ready=1 -> data=%h", 8'hA5);

    // 2: consumer stalled, back-to-back second frame overruns
    out_ready = 1'b0;
    send_frame(8'hA5, 1'b0);
    check("t2_valid", 16'(out_valid), 16'h1);
    send_frame(8'h3C, 1'b0);
    check("t2_overrun", 16'(overrun), 16'h1);
    check("t2_hold_data", 16'(out_data), 16'hA5);
    check("t2_no_frame_err", 16'(frame_err), 16'h0);
    tick(1'b0, 1'b1);
    check("t2_overrun_pulse", 16'(overrun), 16'h0);
    check("t2_still_valid", 16'(out_valid), 16'h1);
    out_ready = 1'b1;
    tick(1'b0, 1'b1);
    check("t2_drop_after_xfer", 16'(out_valid), 16'h0);
    $display("txn 2: A5 held, 3C dropped with overrun");

    // 2b: word completes while the old one transfers in the same cycle
    out_ready = 1'b0;
    send_frame(8'h11, 1'b0);
    send_head(8'h22);
`ifdef PARITY_EN
    tick(1'b0, 1'b1);
`endif
    out_ready = 1'b1;
    tick(1'b0, 1'b1);
    check("t2b_valid_kept", 16'(out_valid), 16'h1);
    check("t2b_new_data", 16'(out_data), 16'h22);
    check("t2b_no_overrun", 16'(overrun), 16'h0);
    tick(1'b0, 1'b1);
    check("t2b_drained", 16'(out_valid), 16'h0);
    $display("txn 2b: 11 transfers while 22 loads");

    // 3: bad stop bit
    send_frame(8'hFF, 1'b1);
    check("t3_frame_err", 16'(frame_err), 16'h1);
    check("t3_no_valid", 16'(out_valid), 16'h0);
    check("t3_idle", 16'(busy), 16'h0);
    tick(1'b0, 1'b1);
    check("t3_pulse", 16'(frame_err), 16'h0);
    // frame error takes priority over overrun while a word is pending
    out_ready = 1'b0;
    send_frame(8'h42, 1'b0);
    send_frame(8'hFF, 1'b1);
    check("t3b_frame_err", 16'(frame_err), 16'h1);
    check("t3b_no_overrun", 16'(overrun), 16'h0);
    check("t3b_held", 16'(out_data), 16'h42);
    out_ready = 1'b1;
    tick(1'b0, 1'b1);
    $display("txn 3: FF with stop=1 -> frame_err");

    // 4: bit_en toggles; disabled cycles carry the opposite level to prove they are ignored
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      tick(8'h5A >> i, 1'b1);
      tick(~(8'h5A >> i), 1'b0);
    end
`ifdef PARITY_EN
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
`endif
    check("t4_busy_held", 16'(busy), 16'h1);
    tick(1'b0, 1'b1);
    check("t4_valid", 16'(out_valid), 16'h1);
    check("t4_data", 16'(out_data), 16'h5A);
    tick(1'b0, 1'b0);
    $display("txn 4: 5A with toggling bit_en");

    // 5: reset mid-frame with a word pending
    out_ready = 1'b0;
    send_frame(8'h99, 1'b0);
    tick(1'b1, 1'b1);
    for (int i = 7; i >= 4; i--) tick(8'hC3 >> i, 1'b1);
    reset = 1'b1;
    tick(1'b1, 1'b1);
    check("t5_valid", 16'(out_valid), 16'h0);
    check("t5_data", 16'(out_data), 16'h00);
    check("t5_busy", 16'(busy), 16'h0);
    reset = 1'b0;
    out_ready = 1'b1;
    send_frame(8'h81, 1'b0);
    check("t5_next_valid", 16'(out_valid), 16'h1);
    check("t5_next_data", 16'(out_data), 16'h81);
    tick(1'b0, 1'b1);
    $display("txn 5: reset mid-frame, then 81 received");

`ifdef PARITY_EN
    // 6: even parity on 07 (three ones)
    send_head(8'h07);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    check("t6_good_valid", 16'(out_valid), 16'h1);
    check("t6_good_data", 16'(out_data), 16'h07);
    check("t6_good_perr", 16'(parity_err), 16'h0);
    tick(1'b0, 1'b1);
    send_head(8'h07);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    check("t6_bad_perr", 16'(parity_err), 16'h1);
    check("t6_bad_valid", 16'(out_valid), 16'h0);
    tick(1'b0, 1'b1);
    check("t6_perr_pulse", 16'(parity_err), 16'h0);
    $display("txn 6: parity accept/reject on 07");
`else
    check("no_parity_err", 16'(parity_err), 16'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
